// File: rtl/sub_result_acc_pkg.sv
// Shared types and helpers for the subtraction-result batch accumulator.
//   acc_state_t   : controller states (INIT, ACCUM, EMIT)
//   default_sum_w : accumulator width that cannot overflow for a full batch
package sub_result_acc_pkg;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_EMIT  = 2'd2
    } acc_state_t;

    // A batch of `batch` values of `data_w` bits needs log2(batch) guard bits.
    function automatic int default_sum_w(input int data_w, input int batch);
        return data_w + $clog2(batch);
    endfunction

endpackage

// File: rtl/acc_stat_update.sv
// Combinational statistics step: folds one new signed sample into the running
// sum/min/max/count. The same result feeds both the running accumulators and
// the record registers, so a record always matches what was accumulated.
// Ports:
//   sum_i/min_i/max_i/count_i : current running statistics
//   data_i                    : new signed sample
//   first_i                   : sample is the first of its batch (min/max load directly)
//   sum_o/min_o/max_o/count_o : statistics including data_i
module acc_stat_update #(
    parameter int DATA_W = 32,
    parameter int SUM_W  = 35,
    parameter int CNT_W  = 4
) (
    input  logic signed [SUM_W-1:0]  sum_i,
    input  logic signed [DATA_W-1:0] min_i,
    input  logic signed [DATA_W-1:0] max_i,
    input  logic        [CNT_W-1:0]  count_i,
    input  logic signed [DATA_W-1:0] data_i,
    input  logic                     first_i,
    output logic signed [SUM_W-1:0]  sum_o,
    output logic signed [DATA_W-1:0] min_o,
    output logic signed [DATA_W-1:0] max_o,
    output logic        [CNT_W-1:0]  count_o
);

    logic signed [SUM_W-1:0] data_ext;

    always_comb begin
        data_ext = {{(SUM_W-DATA_W){data_i[DATA_W-1]}}, data_i};
        sum_o    = sum_i + data_ext;
        count_o  = count_i + CNT_W'(1);
        if (first_i) begin
            min_o = data_i;
            max_o = data_i;
        end else begin
            min_o = (data_i < min_i) ? data_i : min_i;
            max_o = (data_i > max_i) ? data_i : max_i;
        end
    end

endmodule

// File: rtl/sub_result_accumulator.sv
// Batches signed subtractor results and emits one statistics record
// (sum, min, max, count) per batch of BATCH results, or per flushed partial batch.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_INIT  | one cycle after reset; raises in_ready on exit
// ST_ACCUM | accepting results; closes batch on BATCH-th result or flush
// ST_EMIT  | record held on out_*; waits for out_ready
//
// Ports:
//   clk, rst                : clock, synchronous active-high reset
//   in_data/in_valid/in_ready : input result stream (in_ready registered)
//   flush                   : close the current non-empty partial batch
//   out_sum/out_min/out_max/out_count : record contents, hold last record
//   out_valid/out_ready     : record handshake (out_valid registered)
module sub_result_accumulator
    import sub_result_acc_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int BATCH  = 8,
    parameter int SUM_W  = default_sum_w(DATA_W, BATCH)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic        [DATA_W-1:0]        in_data,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic                            flush,
    output logic        [SUM_W-1:0]         out_sum,
    output logic        [DATA_W-1:0]        out_min,
    output logic        [DATA_W-1:0]        out_max,
    output logic        [$clog2(BATCH+1)-1:0] out_count,
    output logic                            out_valid,
    input  logic                            out_ready
);

    localparam int CNT_W = $clog2(BATCH+1);

    acc_state_t state_q, state_d;

    logic                     in_ready_q,  in_ready_d;
    logic                     out_valid_q, out_valid_d;

    logic signed [SUM_W-1:0]  sum_q,   sum_d;
    logic signed [DATA_W-1:0] min_q,   min_d;
    logic signed [DATA_W-1:0] max_q,   max_d;
    logic        [CNT_W-1:0]  count_q, count_d;

    logic signed [SUM_W-1:0]  out_sum_q,   out_sum_d;
    logic signed [DATA_W-1:0] out_min_q,   out_min_d;
    logic signed [DATA_W-1:0] out_max_q,   out_max_d;
    logic        [CNT_W-1:0]  out_count_q, out_count_d;

    logic signed [SUM_W-1:0]  upd_sum;
    logic signed [DATA_W-1:0] upd_min;
    logic signed [DATA_W-1:0] upd_max;
    logic        [CNT_W-1:0]  upd_count;

    logic                     xfer;
    logic signed [SUM_W-1:0]  post_sum;
    logic signed [DATA_W-1:0] post_min;
    logic signed [DATA_W-1:0] post_max;
    logic        [CNT_W-1:0]  post_count;

    acc_stat_update #(
        .DATA_W (DATA_W),
        .SUM_W  (SUM_W),
        .CNT_W  (CNT_W)
    ) u_update (
        .sum_i   (sum_q),
        .min_i   (min_q),
        .max_i   (max_q),
        .count_i (count_q),
        .data_i  ($signed(in_data)),
        .first_i (count_q == '0),
        .sum_o   (upd_sum),
        .min_o   (upd_min),
        .max_o   (upd_max),
        .count_o (upd_count)
    );

    // in_ready is only ever high in ACCUM, so a transfer implies ACCUM.
    assign xfer       = in_valid && in_ready_q;
    // Statistics as they stand after this edge's (possible) transfer; both the
    // batch-complete and flush decisions look at these.
    assign post_sum   = xfer ? upd_sum   : sum_q;
    assign post_min   = xfer ? upd_min   : min_q;
    assign post_max   = xfer ? upd_max   : max_q;
    assign post_count = xfer ? upd_count : count_q;

    always_comb begin
        state_d     = state_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        sum_d       = sum_q;
        min_d       = min_q;
        max_d       = max_q;
        count_d     = count_q;
        out_sum_d   = out_sum_q;
        out_min_d   = out_min_q;
        out_max_d   = out_max_q;
        out_count_d = out_count_q;

        unique case (state_q)
            ST_INIT: begin
                in_ready_d = 1'b1;
                state_d    = ST_ACCUM;
            end
            ST_ACCUM: begin
                sum_d   = post_sum;
                min_d   = post_min;
                max_d   = post_max;
                count_d = post_count;
                if ((post_count == CNT_W'(BATCH)) || (flush && (post_count != '0))) begin
                    out_sum_d   = post_sum;
                    out_min_d   = post_min;
                    out_max_d   = post_max;
                    out_count_d = post_count;
                    in_ready_d  = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    sum_d       = '0;
                    min_d       = '0;
                    max_d       = '0;
                    count_d     = '0;
                    state_d     = ST_ACCUM;
                end
            end
            default: begin
                in_ready_d  = 1'b0;
                out_valid_d = 1'b0;
                state_d     = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_INIT;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            min_q       <= '0;
            max_q       <= '0;
            count_q     <= '0;
            out_sum_q   <= '0;
            out_min_q   <= '0;
            out_max_q   <= '0;
            out_count_q <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            sum_q       <= sum_d;
            min_q       <= min_d;
            max_q       <= max_d;
            count_q     <= count_d;
            out_sum_q   <= out_sum_d;
            out_min_q   <= out_min_d;
            out_max_q   <= out_max_d;
            out_count_q <= out_count_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_min   = out_min_q;
    assign out_max   = out_max_q;
    assign out_count = out_count_q;

endmodule

// File: tb/tb_sub_result_accumulator.sv
module tb_sub_result_accumulator;

    localparam int DW = 8;
    localparam int B  = 4;
    localparam int SW = 10;
    localparam int CW = 3;

    localparam int M_INIT = 0;
    localparam int M_ACC  = 1;
    localparam int M_EMIT = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic          flush;
    logic [SW-1:0] out_sum;
    logic [DW-1:0] out_min;
    logic [DW-1:0] out_max;
    logic [CW-1:0] out_count;
    logic          out_valid;
    logic          out_ready;

    always #5 clk = ~clk;

    sub_result_accumulator #(.DATA_W(DW), .BATCH(B)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_sum   (out_sum),
        .out_min   (out_min),
        .out_max   (out_max),
        .out_count (out_count),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: protocol phase, accepted values of the open batch,
    // and the last emitted record.
    int mstate = M_INIT;
    int batch[$];
    int l_sum = 0, l_min = 0, l_max = 0, l_cnt = 0;
    int rec_exp = 0;
    int rec_dut = 0;

    typedef struct {
        int d[4];
        int n;
        int mode;   // 0: no flush, 1: flush with last item, 2: flush cycle afterwards
        int es;
        int emin;
        int emax;
        int ecnt;
    } vec_t;

    vec_t tbl[6];

    always @(posedge clk) if (!rst && out_valid && out_ready) rec_dut++;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        if (rst) begin
            mstate = M_INIT;
            batch.delete();
            l_sum = 0; l_min = 0; l_max = 0; l_cnt = 0;
        end else begin
            case (mstate)
                M_INIT: mstate = M_ACC;
                M_ACC: begin
                    if (in_valid) batch.push_back(int'($signed(in_data)));
                    if (batch.size() == B || (flush && batch.size() > 0)) begin
                        l_sum = 0;
                        l_min = batch[0];
                        l_max = batch[0];
                        foreach (batch[i]) begin
                            l_sum += batch[i];
                            if (batch[i] < l_min) l_min = batch[i];
                            if (batch[i] > l_max) l_max = batch[i];
                        end
                        l_cnt = batch.size();
                        batch.delete();
                        rec_exp++;
                        mstate = M_EMIT;
                    end
                end
                default: if (out_ready) mstate = M_ACC;
            endcase
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        chk("in_ready",  int'(in_ready),  int'(mstate == M_ACC));
        chk("out_valid", int'(out_valid), int'(mstate == M_EMIT));
        chk("out_sum",   int'($signed(out_sum)), l_sum);
        chk("out_min",   int'($signed(out_min)), l_min);
        chk("out_max",   int'($signed(out_max)), l_max);
        chk("out_count", int'(out_count), l_cnt);
    endtask

    task automatic wait_ready();
        int k = 0;
        while (!in_ready && k < 20) begin
            step();
            k++;
        end
        if (!in_ready) chk("in_ready_timeout", int'(in_ready), 1);
    endtask

    task automatic wait_valid();
        int k = 0;
        while (!out_valid && k < 20) begin
            step();
            k++;
        end
        if (!out_valid) chk("out_valid_timeout", int'(out_valid), 1);
    endtask

    task automatic feed(input int v);
        wait_ready();
        in_valid = 1'b1;
        in_data  = DW'(v);
        step();
        in_valid = 1'b0;
    endtask

    task automatic run_vec(input int idx);
        vec_t v;
        v = tbl[idx];
        out_ready = 1'b1;
        for (int i = 0; i < v.n; i++) begin
            wait_ready();
            in_valid = 1'b1;
            in_data  = DW'(v.d[i]);
            flush    = (v.mode == 1) && (i == v.n - 1);
            step();
            in_valid = 1'b0;
            flush    = 1'b0;
        end
        if (v.mode == 2) begin
            flush = 1'b1;
            step();
            flush = 1'b0;
        end
        wait_valid();
        chk($sformatf("vec%0d_sum", idx),   int'($signed(out_sum)), v.es);
        chk($sformatf("vec%0d_min", idx),   int'($signed(out_min)), v.emin);
        chk($sformatf("vec%0d_max", idx),   int'($signed(out_max)), v.emax);
        chk($sformatf("vec%0d_count", idx), int'(out_count),        v.ecnt);
        step();
        chk($sformatf("vec%0d_single_cycle", idx), int'(out_valid), 0);
        if (v.mode != 0) begin
            flush = 1'b1;
            step();
            flush = 1'b0;
            for (int k = 0; k < 3; k++) begin
                step();
                chk($sformatf("vec%0d_no_empty_record", idx), int'(out_valid), 0);
            end
        end
    endtask

    initial begin
        tbl[0] = '{'{5, -3, 10, 0},         4, 0,   12,   -3,   10, 4};
        tbl[1] = '{'{-128, -128, -128, -128}, 4, 0, -512, -128, -128, 4};
        tbl[2] = '{'{127, 127, 127, 127},   4, 0,  508,  127,  127, 4};
        tbl[3] = '{'{7, -2, 0, 0},          2, 2,    5,   -2,    7, 2};
        tbl[4] = '{'{1, 2, 3, 4},           4, 1,   10,    1,    4, 4};
        tbl[5] = '{'{-1, 0, 0, 0},          1, 1,   -1,   -1,   -1, 1};

        rst = 1'b1; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b0;
        step();
        step();
        chk("reset_in_ready", int'(in_ready), 0);
        chk("reset_out_sum",  int'(out_sum),  0);
        rst = 1'b0;
        step();
        chk("init_ready_after_one", int'(in_ready), 1);

        for (int i = 0; i < 6; i++) run_vec(i);

        // Backpressure: record must sit still while upstream waits.
        out_ready = 1'b0;
        feed(1); feed(2); feed(3); feed(4);
        in_valid = 1'b1;
        in_data  = DW'(99);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("bp_hold_sum",   int'($signed(out_sum)), 10);
            chk("bp_hold_ready", int'(in_ready), 0);
        end
        out_ready = 1'b1;
        step();
        chk("bp_release_valid", int'(out_valid), 0);
        chk("bp_release_ready", int'(in_ready),  1);
        step();
        in_valid = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        wait_valid();
        chk("bp_held_item_sum",   int'($signed(out_sum)), 99);
        chk("bp_held_item_count", int'(out_count),        1);
        step();

        // Reset mid-batch discards the partial batch.
        feed(9); feed(9); feed(9);
        rst = 1'b1;
        step();
        chk("rst_mid_sum", int'(out_sum),  0);
        step();
        rst = 1'b0;
        step();
        chk("post_rst_count", int'(out_count), 0);
        feed(1); feed(1); feed(1); feed(1);
        wait_valid();
        chk("post_rst_sum",   int'($signed(out_sum)), 4);
        chk("post_rst_count", int'(out_count),        4);
        step();

        // Random traffic against the model.
        for (int c = 0; c < 600; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = DW'($urandom);
            flush     = ($urandom_range(0, 9) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 4; c++) step();

        chk("record_count", rec_dut, rec_exp);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
